// File: rtl/seg_scan_pkg.sv
// ----------------------------------------------------------------
// seg_scan_pkg: shared types and constants for the display scanner.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package seg_scan_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  function automatic logic [3:0] nibble_sel(input logic [15:0] word,
                                            input logic [1:0]  idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_slot_timer.sv
// ----------------------------------------------------------------
// slot_timer: per-digit slot counter with dead-time and slot-end strobes.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module slot_timer
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES = 16,
  parameter int DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic dead_end,
  output logic slot_end
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] c_dead_last = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr || slot_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dead_end = (r_cnt == c_dead_last);
  assign slot_end = (r_cnt == c_slot_last);

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ----------------------------------------------------------------
// display_scan_ctrl: 4-digit common-anode seven-segment scan controller.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module display_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES = 16,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           data_in,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic                  load,
  output logic [3:0]            char,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done,
  output logic                  pending
);

  scan_state_t           r_state, w_state_nxt;
  logic [1:0]            r_digit, w_digit_nxt;
  logic [15:0]           r_active_data, w_active_data_nxt;
  logic [NUM_DIGITS-1:0] r_active_mask, w_active_mask_nxt;
  logic [15:0]           r_pend_data, w_pend_data_nxt;
  logic [NUM_DIGITS-1:0] r_pend_mask, w_pend_mask_nxt;
  logic                  r_pending, w_pending_nxt;
  logic [3:0]            r_char, w_char_nxt;
  logic [NUM_DIGITS-1:0] r_an, w_an_nxt;
  logic                  r_frame_done;
  logic                  w_boundary;
  logic                  w_timer_clr;
  logic                  w_dead_end;
  logic                  w_slot_end;

  // The counter only runs while actively scanning; any stop restarts the slot.
  assign w_timer_clr = (r_state == IDLE) || !enable;

  slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_slot_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_timer_clr),
    .dead_end (w_dead_end),
    .slot_end (w_slot_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_digit       <= 2'd3;
      r_active_data <= '0;
      r_active_mask <= 4'b1111;
      r_pend_data   <= '0;
      r_pend_mask   <= '0;
      r_pending     <= 1'b0;
      r_char        <= 4'h0;
      r_an          <= AN_OFF;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_digit       <= w_digit_nxt;
      r_active_data <= w_active_data_nxt;
      r_active_mask <= w_active_mask_nxt;
      r_pend_data   <= w_pend_data_nxt;
      r_pend_mask   <= w_pend_mask_nxt;
      r_pending     <= w_pending_nxt;
      r_char        <= w_char_nxt;
      r_an          <= w_an_nxt;
      r_frame_done  <= w_boundary;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_digit_nxt       = r_digit;
    w_active_data_nxt = r_active_data;
    w_active_mask_nxt = r_active_mask;
    w_pend_data_nxt   = r_pend_data;
    w_pend_mask_nxt   = r_pend_mask;
    w_pending_nxt     = r_pending;
    w_char_nxt        = r_char;
    w_an_nxt          = AN_OFF;
    w_boundary        = 1'b0;

    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = BLANK;
          w_digit_nxt = 2'd3;
        end
      end
      BLANK: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_digit_nxt = 2'd3;
        end else if (w_dead_end) begin
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_digit_nxt = 2'd3;
        end else if (w_slot_end) begin
          w_state_nxt = BLANK;
          w_digit_nxt = r_digit - 1'b1;
          w_boundary  = (r_digit == 2'd0);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_digit_nxt = 2'd3;
      end
    endcase

    // A boundary load beats the older pending word; an idle load supersedes it.
    if (r_state == IDLE) begin
      if (load) begin
        w_active_data_nxt = data_in;
        w_active_mask_nxt = digit_en;
        w_pending_nxt     = 1'b0;
      end
    end else if (w_boundary) begin
      if (load) begin
        w_active_data_nxt = data_in;
        w_active_mask_nxt = digit_en;
      end else if (r_pending) begin
        w_active_data_nxt = r_pend_data;
        w_active_mask_nxt = r_pend_mask;
      end
      w_pending_nxt = 1'b0;
    end else if (load) begin
      w_pend_data_nxt = data_in;
      w_pend_mask_nxt = digit_en;
      w_pending_nxt   = 1'b1;
    end

    // The character only moves on BLANK entry, so it never changes under a lit anode.
    if (w_state_nxt == BLANK && r_state != BLANK) begin
      w_char_nxt = nibble_sel(w_active_data_nxt, w_digit_nxt);
    end

    if (w_state_nxt == DRIVE && w_active_mask_nxt[w_digit_nxt]) begin
      w_an_nxt[w_digit_nxt] = 1'b0;
    end
  end

  assign char       = r_char;
  assign an         = r_an;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ----------------------------------------------------------------
// tb_display_scan_ctrl: directed and random bench with frame-position model.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_display_scan_ctrl;

  localparam int SLOT  = 16;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  char;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  display_scan_ctrl #(
    .SLOT_CYCLES (SLOT),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .digit_en   (digit_en),
    .load       (load),
    .char       (char),
    .an         (an),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Model: scanning is a position within a 4*SLOT frame, not a state machine.
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_adata = 16'h0;
  logic [3:0]  m_amask = 4'hF;
  logic [15:0] m_pdata = 16'h0;
  logic [3:0]  m_pmask = 4'h0;
  bit          m_pending = 1'b0;
  logic [3:0]  m_char = 4'h0;
  bit          m_fd = 1'b0;
  bit          m_bnd = 1'b0;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_adata = 16'h0; m_amask = 4'hF;
    m_pdata = 16'h0; m_pmask = 4'h0; m_pending = 0; m_char = 4'h0; m_fd = 0;
  endtask

  task automatic model_step();
    m_bnd = 0;
    if (!m_run) begin
      if (load) begin
        m_adata = data_in; m_amask = digit_en; m_pending = 0;
      end
      if (enable) begin
        m_run = 1; m_pos = 0;
      end
    end else begin
      m_bnd = enable && (m_pos == FRAME - 1);
      if (m_bnd) begin
        if (load) begin
          m_adata = data_in; m_amask = digit_en;
        end else if (m_pending) begin
          m_adata = m_pdata; m_amask = m_pmask;
        end
        m_pending = 0;
      end else if (load) begin
        m_pdata = data_in; m_pmask = digit_en; m_pending = 1;
      end
      if (enable) m_pos = (m_pos + 1) % FRAME;
      else        m_run = 0;
    end
    m_fd = m_bnd;
    if (m_run) m_char = m_adata[4 * (3 - m_pos / SLOT) +: 4];
  endtask

  function automatic logic [3:0] exp_an();
    int d;
    logic [3:0] a;
    a = 4'hF;
    if (m_run) begin
      d = 3 - m_pos / SLOT;
      if ((m_pos % SLOT) >= DEAD && m_amask[d]) a[d] = 1'b0;
    end
    return a;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_an",         16'(an),         16'(exp_an()));
      chk("model_char",       16'(char),       16'(m_char));
      chk("model_frame_done", 16'(frame_done), 16'(m_fd));
      chk("model_pending",    16'(pending),    16'(m_pending));
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    adv(2);
    chk("rst_an",   16'(an),         16'hF);
    chk("rst_char", 16'(char),       16'h0);
    chk("rst_fd",   16'(frame_done), 16'h0);
    chk("rst_pend", 16'(pending),    16'h0);
    reset  = 1'b1;
    chk_en = 1'b1;
    adv(1);

    // Basic scan of 1A3F.
    load = 1; data_in = 16'h1A3F; digit_en = 4'hF;
    adv(1);
    load = 0; enable = 1;
    adv(1);
    chk("blank3_char", 16'(char), 16'h1);
    chk("blank3_an",   16'(an),   16'hF);
    adv(2);
    chk("drive3_an",   16'(an),   16'h7);
    adv(14);
    chk("blank2_char", 16'(char), 16'hA);
    chk("blank2_an",   16'(an),   16'hF);
    adv(2);
    chk("drive2_an",   16'(an),   16'hB);
    adv(46);
    chk("frame1_fd",   16'(frame_done), 16'h1);
    chk("frame1_char", 16'(char),       16'h1);
    adv(1);
    chk("fd_one_cycle", 16'(frame_done), 16'h0);

    // Mid-frame load during digit 2's slot.
    adv(18);
    load = 1; data_in = 16'hBEEF; digit_en = 4'hF;
    adv(1);
    load = 0;
    chk("midload_pend", 16'(pending), 16'h1);
    chk("midload_old",  16'(char),    16'hA);
    adv(44);
    chk("newframe_char", 16'(char),       16'hB);
    chk("newframe_pend", 16'(pending),    16'h0);
    chk("newframe_fd",   16'(frame_done), 16'h1);

    // Load exactly on the boundary cycle, with a 1010 mask.
    adv(63);
    load = 1; data_in = 16'h0C0D; digit_en = 4'b1010;
    adv(1);
    load = 0;
    chk("bndload_char", 16'(char),       16'h0);
    chk("bndload_pend", 16'(pending),    16'h0);
    chk("bndload_fd",   16'(frame_done), 16'h1);
    adv(2);
    chk("mask_d3_on",  16'(an), 16'h7);
    adv(16);
    chk("mask_d2_off", 16'(an), 16'hF);
    adv(16);
    chk("mask_d1_on",  16'(an), 16'hD);

    // Enable drop mid-DRIVE of digit 1, idle load, then re-enable.
    adv(6);
    enable = 0;
    adv(1);
    chk("drop_an", 16'(an), 16'hF);
    adv(2);
    load = 1; data_in = 16'h5C0D; digit_en = 4'hF;
    adv(1);
    load = 0; enable = 1;
    adv(1);
    chk("reen_char", 16'(char), 16'h5);
    chk("reen_an",   16'(an),   16'hF);
    adv(2);
    chk("reen_drive", 16'(an), 16'h7);

    // Asynchronous reset between edges during DRIVE, with a word pending.
    load = 1; data_in = 16'h9999;
    adv(1);
    load = 0;
    adv(4);
    #2 reset = 0;
    #1;
    chk("areset_an",   16'(an),         16'hF);
    chk("areset_char", 16'(char),       16'h0);
    chk("areset_fd",   16'(frame_done), 16'h0);
    chk("areset_pend", 16'(pending),    16'h0);
    enable = 0;
    adv(2);
    reset = 1;

    // Randomised traffic with occasional enable drops.
    enable = 1;
    for (int i = 0; i < 4000; i++) begin
      adv(1);
      load     = ($urandom_range(0, 5) == 0);
      data_in  = 16'($urandom);
      digit_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 9) == 0) enable = 1;
    end
    adv(1);
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display sharing one `LEDdecoder`. It holds a 16-bit hex word (four 4-bit characters), steps through the digits one at a time, presents each digit's character to the decoder's `char` input and drives the matching active-low anode. A dead-time of blanked anodes separates digits to suppress ghosting. New words are double-buffered and take effect only at a frame boundary, so a displayed frame never mixes old and new characters.

## Interface
- `SLOT_CYCLES`, default 16: clock cycles per digit slot (board builds use 65536). Legal range: `DEAD_CYCLES` < `SLOT_CYCLES`.
- `DEAD_CYCLES`, default 2: blanked cycles at the start of each slot. Must be ≥ 1.
- `clk`  in  1  system clock. All sequential logic is on the rising edge.
- `reset`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  scanning enable. Level-sensitive.
- `data_in`  in  16  four characters: [15:12] is digit 3 (leftmost), [3:0] is digit 0.
- `digit_en`  in  4  per-digit display mask. Captured together with `data_in`.
- `load`  in  1  single-cycle strobe that captures `data_in` and `digit_en`.
- `char`  out  4  character to `LEDdecoder.char`. Registered.
- `an`  out  4  anodes, active-low. Bit i selects digit i. Registered.
- `frame_done`  out  1  one-cycle pulse per completed frame. Registered.
- `pending`  out  1  high while a loaded word waits for the next frame boundary.

## Operation
- **Registers:** `active_data`/`active_mask` feed the display; `pend_data`/`pend_mask` hold a loaded word; `digit` (2 b); slot counter `cnt`; `state` ∈ {IDLE, BLANK, DRIVE}.
- **Reset values:**
  - outputs: `an`=4'b1111, `char`=4'h0, `frame_done`=0, `pending`=0
  - internal: `state`=IDLE, `digit`=3, `cnt`=0, `active_data`=16'h0000, `active_mask`=4'b1111, `pend_*`=0
- **IDLE:** `an`=1111 and `char` holds. A `load` writes `active_*` directly; `pending` stays 0. When `enable`=1, go to BLANK with `digit`=3 and `cnt`=0.
- **BLANK:** `an`=1111 and `char` = `active_data` nibble for `digit`. `cnt`++. When `cnt`==`DEAD_CYCLES`-1, go to DRIVE.
- **DRIVE:** `an[digit]`=0 if `active_mask[digit]`=1; all other bits are 1. `cnt`++. When `cnt`==`SLOT_CYCLES`-1:
  - `cnt`←0
  - `digit`←`digit`-1, wrapping 0→3
  - go to BLANK
- **Frame boundary:** the DRIVE end-of-slot cycle with `digit`=0. At this cycle:
  - `frame_done` pulses on the following cycle.
  - If `pending`=1: `active_*`←`pend_*` and `pending`←0.
- **Load outside IDLE, not on a boundary cycle:** `pend_*`←inputs and `pending`←1. A later load overwrites an earlier unapplied one (last load wins).
- **Load on the boundary cycle:** `data_in`/`digit_en` go straight to `active_*` and `pending`←0. This takes priority over the old pending word.
- **`enable`=0 in BLANK/DRIVE:** next state is IDLE, `an`←1111, `digit`←3, `cnt`←0. Pending contents are retained and applied on the first boundary after re-enable.
- **Reset mid-operation:** all registers return to their reset values immediately, without waiting for a clock edge.

## Timing
- Slot length = `SLOT_CYCLES`. Frame length = 4×`SLOT_CYCLES`. Each enabled digit's anode is low for `SLOT_CYCLES`−`DEAD_CYCLES` consecutive cycles per frame.
- `char` changes only on the BLANK entry edge, i.e. only while `an`=1111. It is stable for the whole DRIVE interval.
- `enable` sampled high at edge k: BLANK starts at k, `an[3]` goes low at edge k+`DEAD_CYCLES`.
- `frame_done` is high during the first BLANK cycle of the next frame. Period = 4×`SLOT_CYCLES`.
- Latency from `load` to display ≤ one frame + `DEAD_CYCLES` cycles.
- A masked digit still consumes its full slot; its anode stays 1111-blank throughout.

## Structure
- Package `seg_scan_pkg` holds:
  - the state typedef {IDLE, BLANK, DRIVE}
  - `NUM_DIGITS`=4
  - `AN_OFF`=4'b1111
- One natural sub-module, `slot_timer`: a parameterised `cnt` counter that outputs `dead_end` and `slot_end` strobes and takes a synchronous clear.
- `LEDdecoder` is not instantiated here. The display top wires `char` to it.

## Test plan
Defaults `SLOT_CYCLES`=16 and `DEAD_CYCLES`=2 unless stated.
1. **Basic scan:** reset, load 16'h1A3F with `digit_en`=1111, then enable → `char` sequence 1,A,3,F. `an` goes 0111, 1011, 1101, 1110, each low for 14 cycles after 2 cycles of 1111. `frame_done` pulses every 64 cycles.
2. **Digit mask:** load `digit_en`=4'b1010 → `an[2]` and `an[0]` never go low. `an[3]` and `an[1]` keep their 14-cycle windows. The frame is still 64 cycles.
3. **Mid-frame load:** load 16'hBEEF during digit 2's slot → `pending`=1 and the rest of the frame still shows the old word. The next frame shows B,E,E,F, and `pending` falls at the boundary.
4. **Boundary load:** `load` 16'h0C0D on the exact boundary cycle → the next frame shows 0,C,0,D and `pending` never rises.
5. **Enable drop:** deassert `enable` mid-DRIVE of digit 1 → `an`=1111 next cycle, IDLE. Re-enable → restart at digit 3 BLANK with correct `char`.
6. **Async reset:** assert `reset`=0 between clock edges during DRIVE → immediately `an`=1111, `char`=0, `frame_done`=0, `pending`=0.
